onehot_decoder_seq: RTL
=======================

# onehot_decoder_seq

Parametrised, registered binary-to-one-hot decoder with a built-in auto-scan sequencer. It generalises the fixed 3:8 combinational decoder to SEL_W select bits and 2^SEL_W outputs. It adds an enable, a registered output stage and a scan mode that walks the active line around the output vector with a programmable dwell time. It drives row/column strobes, mux selects and round-robin channel enables.

## Interface
- SEL_W, default 3: select width; OUT_W = 2**SEL_W, a derived localparam. Legal range is 1..6.
- DWELL_W, default 8: width of the dwell counter.
- clk, input, 1: clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous active-low reset, single clock domain.
- en, input, 1: block enable; when low, no output line is active.
- mode, input, 1: 0 = direct decode, 1 = auto-scan.
- sel, input, SEL_W: direct-mode select, and the start index for scan.
- dwell, input, DWELL_W: cycles-per-step minus 1; sampled at scan start only.
- D, output, OUT_W: registered one-hot output, or all zero.
- idx, output, SEL_W: binary index of the active line; holds its last value when D = 0.
- active, output, 1: high when D is non-zero.
- wrap, output, 1: one-cycle pulse when scan advances from OUT_W-1 to 0.

## Operation
- States:
  - IDLE: D = 0.
  - DIRECT: D = one-hot(sel), re-evaluated every cycle.
  - SCAN: D = one-hot(idx); idx steps after each dwell period.
- Transitions, evaluated every cycle with priority top-down:
  - en = 0: go to IDLE.
  - en = 1 and mode = 0: go to DIRECT.
  - en = 1, mode = 1, and current state is not SCAN: go to SCAN.
    - Load idx <= sel.
    - Load the dwell counter cnt <= dwell (sampled this cycle).
  - SCAN with mode = 1: remain in SCAN.
- Scan step:
  - If cnt = 0: idx <= idx+1 (modulo OUT_W) and cnt <= dwell_latched.
  - Otherwise: cnt <= cnt-1.
  - Each line is therefore held for dwell+1 cycles.
  - dwell = 0 advances every cycle.
- The dwell value is latched on SCAN entry. Changes to dwell during a scan are ignored until the next SCAN entry.
- wrap = 1 for exactly the cycle in which idx changes from OUT_W-1 to 0. It is never asserted in DIRECT or IDLE.
- Mode switch mid-scan:
  - SCAN→DIRECT takes effect on the next edge.
  - DIRECT→SCAN restarts from the current sel with a fresh dwell count.
- In DIRECT, idx <= sel.
- D is always one-hot or zero. No other pattern is legal at any time.

## Timing
- All outputs are registered.
- Reset values: D = 0, idx = 0, active = 0, wrap = 0, state = IDLE, cnt = 0.
- Reset assertion clears all outputs immediately (asynchronously). This includes mid-scan.
- After rst_n deasserts, the first state change occurs on the first rising edge.
- Direct latency: sel/en/mode sampled at edge N gives D valid after edge N. That is 1 cycle, with no combinational path from inputs to outputs.
- Scan entry: first line one-hot(sel) appears 1 cycle after en&mode is sampled high. The first advance occurs dwell+1 cycles after that.
- en low → D = 0 after the next edge; idx holds.
- A scan full revolution takes OUT_W*(dwell+1) cycles.

## Configuration
- ONEHOT_DECODER_SEQ_BIDIR_EN:
  - Defined:
    - Adds an input port dir (1 bit). dir = 0 scans upward; dir = 1 scans downward (idx-1 modulo OUT_W).
    - dir is sampled every step.
    - In downward scan, wrap pulses on the 0 → OUT_W-1 transition.
  - Undefined:
    - No dir port; scan is upward only, as described above.
- All other behaviour is identical in both builds.

## Test plan
- Reset value: assert rst_n = 0 mid-scan with SEL_W = 3 → D = 8'h00, idx = 0, active = 0 and wrap = 0 without waiting for a clock edge. After release with en = 0, D stays 0.
- Direct decode: en = 1, mode = 0, sweep sel = 0..7, one per cycle → D = 8'h01, 02, 04, … 80, each 1 cycle after its sel. idx tracks sel and active = 1.
- Scan with dwell: en = 1, mode = 1, sel = 6, dwell = 2 → D = 8'h40 for 3 cycles, then 8'h80 for 3 cycles. Next, D = 8'h01 with wrap high for exactly its first cycle.
- Dwell = 0 and latching: start scan at sel = 0 with dwell = 0 → D advances every cycle; wrap pulses every 8 cycles. Changing dwell to 5 mid-scan has no effect.
- Mode/enable switches: switch mode 1→0 mid-scan with sel = 3 → next cycle D = 8'h08. Switch back to mode = 1 → scan restarts at 3. Drop en → D = 0 the next cycle and idx holds.
- Bidir build: with ONEHOT_DECODER_SEQ_BIDIR_EN defined, dir = 1, sel = 1, dwell = 0 → D goes 8'h02, 8'h01, 8'h80 (with wrap), then 8'h40.

Source files
------------

// File: rtl/onehot_decoder_seq.sv
// -----------------------------------------------------------------------------
// onehot_decoder_seq
//
// Registered binary-to-one-hot decoder with a built-in auto-scan sequencer.
// The block has three operating states:
//   - IDLE   : the block is disabled and the output is all zero.
//   - DIRECT : D is the one-hot decode of sel, re-evaluated every cycle.
//   - SCAN   : the active line walks around the output vector. Each line is
//              held for (dwell + 1) cycles.
// The dwell value is captured when the block enters SCAN. Changing dwell
// during a scan has no effect until the next SCAN entry.
//
// Parameters
//   SEL_W   : select width. The legal range is 1..6.
//             The output width OUT_W is 2**SEL_W.
//   DWELL_W : width of the dwell counter.
//
// Ports
//   clk    in   clock; all state updates on the rising edge
//   rst_n  in   asynchronous active-low reset
//   en     in   block enable; when low, no output line is active
//   mode   in   0 = direct decode, 1 = auto-scan
//   sel    in   [SEL_W]   direct-mode select, and the scan start index
//   dwell  in   [DWELL_W] cycles-per-step minus 1, sampled at scan entry
//   dir    in   (bidir build only) 0 = scan upward, 1 = scan downward;
//               sampled on every step
//   D      out  [OUT_W]   registered one-hot output, or all zero
//   idx    out  [SEL_W]   index of the active line; holds while D = 0
//   active out  high when D is non-zero
//   wrap   out  one-cycle pulse on the scan wrap-around transition
//
// Build option
//   ONEHOT_DECODER_SEQ_BIDIR_EN : when defined, adds the dir port and
//                                 enables downward scanning.
// -----------------------------------------------------------------------------
module onehot_decoder_seq #(
   parameter int SEL_W   = 3,
   parameter int DWELL_W = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    mode,
   input  logic [SEL_W-1:0]        sel,
   input  logic [DWELL_W-1:0]      dwell,
`ifdef ONEHOT_DECODER_SEQ_BIDIR_EN
   input  logic                    dir,
`endif
   output logic [(1<<SEL_W)-1:0]   D,
   output logic [SEL_W-1:0]        idx,
   output logic                    active,
   output logic                    wrap
);

   localparam int OUT_W = 1 << SEL_W;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2
   } state_t;

   state_t               state;
   logic [DWELL_W-1:0]   cnt;
   logic [DWELL_W-1:0]   dwell_lat;

   // Scan direction. The upward-only build ties this low.
   logic                 step_down;
`ifdef ONEHOT_DECODER_SEQ_BIDIR_EN
   assign step_down = dir;
`else
   assign step_down = 1'b0;
`endif

   // Neighbour index for a scan step.
   // Because OUT_W is a power of two, the SEL_W-bit arithmetic wraps
   // modulo OUT_W without any extra logic.
   logic [SEL_W-1:0]     step_idx;
   logic                 step_wrap;

   always_comb begin
      step_idx  = idx;
      step_wrap = 1'b0;
      if (step_down) begin
         step_idx  = idx - SEL_W'(1);
         step_wrap = (idx == '0);
      end else begin
         step_idx  = idx + SEL_W'(1);
         step_wrap = (idx == '1);
      end
   end

   // Scan advances on this edge.
   logic                 scan_step;
   assign scan_step = en && mode && (state == ST_SCAN) && (cnt == '0);

   // Index that will be registered on this edge.
   // The priority order matches the state transitions below:
   //   1. disabled                 : hold the current index
   //   2. direct mode              : follow sel
   //   3. entering scan            : start at sel
   //   4. scan with dwell expired  : step to the neighbour index
   //   5. scan, dwell still running: hold the current index
   logic [SEL_W-1:0]     load_idx;

   always_comb begin
      load_idx = idx;
      if (!en) begin
         load_idx = idx;
      end else if (!mode) begin
         load_idx = sel;
      end else if (state != ST_SCAN) begin
         load_idx = sel;
      end else if (cnt == '0) begin
         load_idx = step_idx;
      end else begin
         load_idx = idx;
      end
   end

   // Decode the next index into a one-hot vector.
   // Exactly one comparator can match, so D can only ever be one-hot or zero.
   logic [OUT_W-1:0]     dec_next;

   generate
      for (genvar gi = 0; gi < OUT_W; gi++) begin : g_dec
         assign dec_next[gi] = (load_idx == SEL_W'(gi));
      end
   endgenerate

   // State machine and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         dwell_lat <= '0;
         D         <= '0;
         idx       <= '0;
         active    <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         idx    <= load_idx;
         D      <= en ? dec_next : '0;
         active <= en;
         wrap   <= scan_step && step_wrap;

         if (!en) begin
            state <= ST_IDLE;
         end else if (!mode) begin
            state <= ST_DIRECT;
         end else if (state != ST_SCAN) begin
            // Fresh scan: capture the dwell value and start the count.
            state     <= ST_SCAN;
            cnt       <= dwell;
            dwell_lat <= dwell;
         end else if (cnt == '0) begin
            // The dwell period has elapsed: reload the count for the next line.
            cnt <= dwell_lat;
         end else begin
            cnt <= cnt - DWELL_W'(1);
         end
      end
   end

endmodule
